// File: rtl/forwarding_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | forwarding_ctrl_if                                                   |
// | ID-stage request and EX-stage selector bundle for forwarding_ctrl.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface forwarding_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  logic                i_stall;
  logic                i_flush;
  logic                i_valid;
  logic [REG_BITS-1:0] i_rs;
  logic [REG_BITS-1:0] i_rt;
  logic [REG_BITS-1:0] i_dst;
  logic                i_reg_write;
  logic                i_mem_read;
  logic [1:0]          o_sel_a;
  logic [1:0]          o_sel_b;
  logic                o_load_use;
  logic [CNT_BITS-1:0] o_fwd_count;

  modport master (
    output i_stall, i_flush, i_valid, i_rs, i_rt, i_dst, i_reg_write, i_mem_read,
    input  o_sel_a, o_sel_b, o_load_use, o_fwd_count
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_rs, i_rt, i_dst, i_reg_write, i_mem_read,
    output o_sel_a, o_sel_b, o_load_use, o_fwd_count
  );
endinterface
`default_nettype wire

// File: rtl/forwarding_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | forwarding_ctrl                                                      |
// | Registered EX-stage operand-mux selectors plus load-use bubble.      |
// | Optional macro FORWARDING_CTRL_STATS_EN adds a forwarding counter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module forwarding_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  forwarding_ctrl_if.slave  bus
);

  localparam logic [1:0] c_SEL_RF  = 2'b00;
  localparam logic [1:0] c_SEL_MEM = 2'b01;
  localparam logic [1:0] c_SEL_EX  = 2'b10;

  logic [REG_BITS-1:0] r_ex_dst;
  logic                r_ex_wr;
  logic                r_ex_ld;
  logic [REG_BITS-1:0] r_mem_dst;
  logic                r_mem_wr;
  logic [1:0]          r_sel_a;
  logic [1:0]          r_sel_b;

  logic w_ex_live;
  logic w_mem_live;
  logic w_load_use;
  logic w_bubble;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // Register 0 is hard-wired, so a write to it is never a forwarding source.
  assign w_ex_live  = r_ex_wr  && (r_ex_dst  != '0);
  assign w_mem_live = r_mem_wr && (r_mem_dst != '0);

  assign w_load_use = bus.i_valid && r_ex_ld && w_ex_live &&
                      ((r_ex_dst == bus.i_rs) || (r_ex_dst == bus.i_rt));
  assign w_bubble   = bus.i_flush || w_load_use;

  always_comb begin
    w_sel_a = c_SEL_RF;
    w_sel_b = c_SEL_RF;
    if (bus.i_valid) begin
      if (w_ex_live && (r_ex_dst == bus.i_rs))
        w_sel_a = c_SEL_EX;
      else if (w_mem_live && (r_mem_dst == bus.i_rs))
        w_sel_a = c_SEL_MEM;
      if (w_ex_live && (r_ex_dst == bus.i_rt))
        w_sel_b = c_SEL_EX;
      else if (w_mem_live && (r_mem_dst == bus.i_rt))
        w_sel_b = c_SEL_MEM;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ex_dst  <= '0;
      r_ex_wr   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_mem_dst <= '0;
      r_mem_wr  <= 1'b0;
      r_sel_a   <= c_SEL_RF;
      r_sel_b   <= c_SEL_RF;
    end else if (!bus.i_stall) begin
      r_mem_dst <= r_ex_dst;
      r_mem_wr  <= r_ex_wr;
      if (w_bubble || !bus.i_valid) begin
        r_ex_dst <= '0;
        r_ex_wr  <= 1'b0;
        r_ex_ld  <= 1'b0;
      end else begin
        r_ex_dst <= bus.i_dst;
        r_ex_wr  <= bus.i_reg_write;
        r_ex_ld  <= bus.i_mem_read;
      end
      r_sel_a <= w_bubble ? c_SEL_RF : w_sel_a;
      r_sel_b <= w_bubble ? c_SEL_RF : w_sel_b;
    end
  end

  assign bus.o_sel_a    = r_sel_a;
  assign bus.o_sel_b    = r_sel_b;
  assign bus.o_load_use = w_load_use;

`ifdef FORWARDING_CTRL_STATS_EN
  localparam logic [CNT_BITS-1:0] c_CNT_MAX = '1;

  logic [CNT_BITS-1:0] r_fwd_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fwd_count <= '0;
    end else if (!bus.i_stall && !w_bubble &&
                 ((w_sel_a != c_SEL_RF) || (w_sel_b != c_SEL_RF)) &&
                 (r_fwd_count != c_CNT_MAX)) begin
      r_fwd_count <= r_fwd_count + 1'b1;
    end
  end

  assign bus.o_fwd_count = r_fwd_count;
`else
  assign bus.o_fwd_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forwarding_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_forwarding_ctrl                                                   |
// | Vector table plus scoreboard for forwarding_ctrl.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_forwarding_ctrl;

`ifdef FORWARDING_CTRL_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  typedef struct {
    logic       st, fl, v;
    logic [4:0] rs, rt, dst;
    logic       wr, ld;
    logic       lu;
    logic [1:0] sa, sb;
  } vec_t;

  typedef struct {
    logic [1:0]  sa, sb;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;
  vec_t vecs[$];
  exp_t sb_q[$];

  forwarding_ctrl_if #(.REG_BITS(5), .CNT_BITS(16)) bus ();

  forwarding_ctrl #(.REG_BITS(5), .CNT_BITS(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic st, fl, v, input logic [4:0] rs, rt, dst,
                     input logic wr, ld, lu, input logic [1:0] sa, sb);
    vec_t t;
    t.st = st; t.fl = fl; t.v = v; t.rs = rs; t.rt = rt; t.dst = dst;
    t.wr = wr; t.ld = ld; t.lu = lu; t.sa = sa; t.sb = sb;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    bus.i_stall     = t.st;
    bus.i_flush     = t.fl;
    bus.i_valid     = t.v;
    bus.i_rs        = t.rs;
    bus.i_rt        = t.rt;
    bus.i_dst       = t.dst;
    bus.i_reg_write = t.wr;
    bus.i_mem_read  = t.ld;
  endtask

  // Drive one ID-stage request, check the combinational hazard, then score the edge.
  task automatic apply(input vec_t t, input int id);
    exp_t e;
    exp_t g;
    @(negedge clk);
    drive(t);
    #1;
    chk($sformatf("load_use[%0d]", id), int'(bus.o_load_use), int'(t.lu));
    if (!t.st && !t.fl && !t.lu && (t.sa != 2'b00 || t.sb != 2'b00))
      exp_cnt++;
    e.sa = t.sa; e.sb = t.sb; e.id = id;
    e.cnt = c_STATS ? 16'(exp_cnt) : 16'd0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      g = sb_q.pop_front();
      chk($sformatf("sel_a[%0d]", g.id), int'(bus.o_sel_a), int'(g.sa));
      chk($sformatf("sel_b[%0d]", g.id), int'(bus.o_sel_b), int'(g.sb));
      chk($sformatf("count[%0d]", g.id), int'(bus.o_fwd_count), int'(g.cnt));
    end
  endtask

  initial begin
    vec_t t;
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    t = '{st:0, fl:0, v:0, rs:0, rt:0, dst:0, wr:0, ld:0, lu:0, sa:0, sb:0};
    drive(t);

    //  st fl v  rs  rt  dst wr ld lu  sa     sb
    add(0, 0, 1,  1,  2,  3, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  3,  4,  9, 0, 0, 0, 2'b10, 2'b00);
    add(0, 0, 1,  3,  3,  5, 1, 0, 0, 2'b01, 2'b01);
    add(0, 0, 1, 10, 11, 12, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  7,  5,  0, 0, 0, 0, 2'b00, 2'b01);
    add(0, 0, 1,  1,  2,  6, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  0,  0,  6, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  6,  6, 13, 0, 0, 0, 2'b10, 2'b10);
    add(0, 0, 1,  1,  2,  0, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1, 14, 15,  0, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  0,  0, 16, 0, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1,  1,  2, 17, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 0, 17, 17, 18, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1, 20, 17, 21, 0, 0, 0, 2'b00, 2'b01);
    add(0, 0, 1,  1,  2,  8, 1, 1, 0, 2'b00, 2'b00);
    add(0, 0, 1,  8,  9, 22, 1, 0, 1, 2'b00, 2'b00);
    add(0, 0, 1,  8,  9, 22, 1, 0, 0, 2'b01, 2'b00);
    add(0, 0, 1,  3,  2,  0, 1, 1, 0, 2'b00, 2'b00);
    add(0, 0, 1,  0, 22, 23, 1, 0, 0, 2'b00, 2'b01);
    add(1, 1, 1, 23, 23, 24, 1, 0, 0, 2'b00, 2'b01);
    add(1, 1, 1, 23, 23, 24, 1, 0, 0, 2'b00, 2'b01);
    add(1, 1, 1, 23, 23, 24, 1, 0, 0, 2'b00, 2'b01);
    add(0, 1, 1, 23, 23, 24, 1, 0, 0, 2'b00, 2'b00);
    add(0, 0, 1, 23,  1,  2, 0, 0, 0, 2'b01, 2'b00);
    add(0, 0, 1,  1,  2, 25, 1, 1, 0, 2'b00, 2'b00);
    add(1, 0, 1, 25,  2, 26, 0, 0, 1, 2'b00, 2'b00);
    add(0, 0, 1, 30, 25,  0, 0, 0, 1, 2'b00, 2'b00);
    add(0, 0, 1, 30, 25,  0, 0, 0, 0, 2'b00, 2'b01);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_sel_a", int'(bus.o_sel_a), 0);
    chk("reset_sel_b", int'(bus.o_sel_b), 0);
    chk("reset_load_use", int'(bus.o_load_use), 0);
    chk("reset_count", int'(bus.o_fwd_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Load a forwarding result and a pending load, then reset asynchronously mid-cycle.
    t = '{st:0, fl:0, v:1, rs:1, rt:2, dst:4, wr:1, ld:0, lu:0, sa:2'b00, sb:2'b00};
    apply(t, 100);
    t = '{st:0, fl:0, v:1, rs:4, rt:1, dst:5, wr:1, ld:1, lu:0, sa:2'b10, sb:2'b00};
    apply(t, 101);
    @(negedge clk);
    t = '{st:1, fl:0, v:1, rs:5, rt:4, dst:0, wr:0, ld:0, lu:1, sa:2'b10, sb:2'b00};
    drive(t);
    #1;
    chk("pre_reset_load_use", int'(bus.o_load_use), 1);
    chk("pre_reset_sel_a", int'(bus.o_sel_a), 2);
    chk("pre_reset_count", int'(bus.o_fwd_count), c_STATS ? exp_cnt : 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_sel_a", int'(bus.o_sel_a), 0);
    chk("async_reset_sel_b", int'(bus.o_sel_b), 0);
    chk("async_reset_load_use", int'(bus.o_load_use), 0);
    chk("async_reset_count", int'(bus.o_fwd_count), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // Both slots must be empty: neither the old EX load nor the old MEM dst=4 may match.
    t = '{st:0, fl:0, v:1, rs:5, rt:4, dst:0, wr:0, ld:0, lu:0, sa:2'b00, sb:2'b00};
    apply(t, 102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
